// File: rtl/dtree_classifier.sv
`default_nettype none
// ============================================================================
// Module   : dtree_classifier
// Purpose  : Streaming spike classifier. A sample at or above THRESHOLD starts
//            a capture of FEATURES samples spaced STRIDE cycles apart. The
//            captured feature vector is then classified by a depth-2 binary
//            tree of linear nodes (sum of coeff*feature compared to a bias).
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high
//            sample     - unsigned input sample, one per cycle
//            level      - class label of the reached leaf (held between pulses)
//            path       - {root decision, second decision} (held)
//            out_valid  - one-cycle pulse marking a new level/path result
// Revision : 1.0 - initial release
// ============================================================================
module dtree_classifier #(
    parameter int FEATURES    = 3,
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4,
    parameter int THRESHOLD   = 512,
    parameter int STRIDE      = 4,
    parameter int ACC_WIDTH   = IN_WIDTH + COEFF_WIDTH + 1 + $clog2(FEATURES) + 1,
    // node2 (f2,f1,f0) = (-1,0,1), node1 = (1,0,0), node0 = (0,1,0)
    parameter logic [3*FEATURES*COEFF_WIDTH-1:0] COEFFS = 36'hF01_100_010,
    parameter logic [3*ACC_WIDTH-1:0] BIASES =
        {ACC_WIDTH'(0), ACC_WIDTH'(300), ACC_WIDTH'(700)},
    parameter logic [7:0] LEAF_LABELS = 8'b11_10_01_00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] sample,
    output logic [1:0]          level,
    output logic [1:0]          path,
    output logic                out_valid
);

    localparam int CNT_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int LEFT_W = $clog2(FEATURES) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_EVAL0   = 3'd2,
        S_EVAL1   = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // Feature shift chain: newest capture enters at the top, so once all
    // FEATURES samples are in, r_feat[k] holds feature k.
    logic [IN_WIDTH-1:0] r_feat [FEATURES];
    logic [CNT_W-1:0]    r_cnt;
    logic [LEFT_W-1:0]   r_left;
    logic                r_d1;
    logic                r_d2;
    logic [1:0]          r_level;
    logic [1:0]          r_path;
    logic                r_valid;

    logic                w_trig;
    logic                w_cap;
    logic [1:0]          w_node;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_bias;
    logic                w_dec;
    logic [1:0]          w_leaf_path;

    // The OUTPUT cycle behaves like IDLE for triggering, so a sample at the
    // edge that drops out_valid can already start the next spike.
    assign w_trig = ((r_state == S_IDLE) || (r_state == S_OUTPUT)) &&
                    (sample >= IN_WIDTH'(THRESHOLD));
    assign w_cap  = (r_state == S_CAPTURE) && (r_cnt == CNT_W'(STRIDE - 1));

    // Node 0 in EVAL0; node 1 + d1 in EVAL1.
    assign w_node = (r_state == S_EVAL1) ? (r_d1 ? 2'd2 : 2'd1) : 2'd0;

    function automatic logic signed [ACC_WIDTH-1:0] node_sum(input logic [1:0] n);
        logic signed [ACC_WIDTH-1:0] acc;
        logic signed [ACC_WIDTH-1:0] cx;
        logic signed [ACC_WIDTH-1:0] fx;
        logic [COEFF_WIDTH-1:0]      c;
        acc = '0;
        for (int k = 0; k < FEATURES; k++) begin
            c   = COEFF_WIDTH'(COEFFS >> ((int'(n) * FEATURES + k) * COEFF_WIDTH));
            cx  = ACC_WIDTH'($signed(c));              // sign-extend coefficient
            fx  = $signed(ACC_WIDTH'(r_feat[k]));      // zero-extend feature
            acc = acc + cx * fx;
        end
        return acc;
    endfunction

    assign w_sum       = node_sum(w_node);
    assign w_bias      = $signed(ACC_WIDTH'(BIASES >> (int'(w_node) * ACC_WIDTH)));
    assign w_dec       = (w_sum >= w_bias);
    assign w_leaf_path = {r_d1, w_dec};

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OUTPUT: begin
                if (w_trig) begin
                    w_state_nxt = (FEATURES == 1) ? S_EVAL0 : S_CAPTURE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (w_cap && (r_left == LEFT_W'(1))) begin
                    w_state_nxt = S_EVAL0;
                end
            end
            S_EVAL0:  w_state_nxt = S_EVAL1;
            S_EVAL1:  w_state_nxt = S_OUTPUT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FEATURES; k++) begin
                r_feat[k] <= '0;
            end
            r_cnt   <= '0;
            r_left  <= '0;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_level <= 2'd0;
            r_path  <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == S_EVAL1);

            if (w_trig || w_cap) begin
                for (int k = 0; k < FEATURES - 1; k++) begin
                    r_feat[k] <= r_feat[k + 1];
                end
                r_feat[FEATURES - 1] <= sample;
                r_cnt <= '0;
                r_left <= w_trig ? LEFT_W'(FEATURES - 1) : (r_left - LEFT_W'(1));
            end else if (r_state == S_CAPTURE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_EVAL0) begin
                r_d1 <= w_dec;
            end

            if (r_state == S_EVAL1) begin
                r_d2    <= w_dec;
                r_path  <= w_leaf_path;
                r_level <= 2'(LEAF_LABELS >> {w_leaf_path, 1'b0});
            end
        end
    end

    assign level     = r_level;
    assign path      = r_path;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dtree_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtree_classifier
// Purpose  : Scoreboard bench for dtree_classifier. A cycle-level reference
//            model tracks triggers and feature captures, computes the tree
//            decision with integer arithmetic and queues the expected result
//            with the edge at which it must appear. A monitor pops and
//            compares whenever out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtree_classifier;

    localparam int F  = 3;
    localparam int S  = 4;
    localparam int TH = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sample = '0;
    logic [1:0] level;
    logic [1:0] path;
    logic       out_valid;

    always #5 clk = ~clk;

    dtree_classifier dut (
        .clk       (clk),
        .reset     (reset),
        .sample    (sample),
        .level     (level),
        .path      (path),
        .out_valid (out_valid)
    );

    typedef struct {
        int         exp;
        logic [1:0] p;
        logic [1:0] l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference tree parameters (match the design defaults).
    int coef [3][3] = '{'{0, 1, 0}, '{0, 0, 1}, '{1, 0, -1}};
    int bias [3]    = '{700, 300, 0};
    int leaf [4]    = '{0, 1, 2, 3};

    int m_feat [F];
    bit m_coll = 1'b0;
    int m_trig = 0;
    int m_free = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit node(input int n);
        int s = 0;
        for (int k = 0; k < F; k++) s += coef[n][k] * m_feat[k];
        return s >= bias[n];
    endfunction

    // Model what the DUT does at edge e given the sample/reset present there.
    task automatic model(input int e, input int s, input bit r);
        exp_t it;
        int   k;
        bit   d1, d2;
        if (r) begin
            m_coll = 1'b0;
            m_free = 0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].exp >= e) sb.delete(i);
            end
        end else if (!m_coll && e >= m_free && s >= TH) begin
            m_trig    = e;
            m_feat[0] = s;
            m_coll    = 1'b1;
            m_free    = e + (F - 1) * S + 3;
        end else if (m_coll && ((e - m_trig) % S) == 0) begin
            k = (e - m_trig) / S;
            m_feat[k] = s;
            if (k == F - 1) begin
                d1     = node(0);
                d2     = node(d1 ? 2 : 1);
                it.exp = e + 2;
                it.p   = {d1, d2};
                it.l   = 2'(leaf[{d1, d2}]);
                sb.push_back(it);
                m_coll = 1'b0;
            end
        end
    endtask

    task automatic drive(input int s, input bit r = 1'b0);
        sample = 10'(s);
        reset  = r;
        model(cyc + 1, s, r);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic spike(input int f0, input int f1, input int f2, input int mid = 100);
        drive(f0);
        drive(100); drive(mid); drive(100);
        drive(f1);
        drive(100); drive(mid); drive(100);
        drive(f2);
    endtask

    // Monitor: every out_valid cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: out_valid=1 at edge %0d, expected none", cyc);
            end else begin
                mon_x = sb.pop_front();
                chk("pulse_edge", cyc, mon_x.exp);
                chk("path", {30'd0, path}, {30'd0, mon_x.p});
                chk("level", {30'd0, level}, {30'd0, mon_x.l});
            end
        end
    end

    initial begin
        repeat (3) drive(100, 1'b1);
        @(negedge clk);
        chk("reset_level", {30'd0, level}, 0);
        chk("reset_path", {30'd0, path}, 0);
        chk("reset_valid", {31'd0, out_valid}, 0);

        // Baseline plus a single just-below-threshold sample: no pulse.
        repeat (10) drive(100);
        drive(TH - 1);
        repeat (10) drive(100);

        spike(600, 800, 200);  repeat (6) drive(100);   // path 11
        spike(600, 650, 400);  repeat (6) drive(100);   // path 01
        spike(600, 650, 100);  repeat (6) drive(100);   // path 00

        // path 10, 600s mid-capture ignored, exact threshold at TL+3 retriggers
        spike(600, 800, 700, 600);
        drive(100); drive(100);
        drive(TH);
        repeat (12) drive(100);

        // Reset 5 edges after trigger aborts the spike.
        drive(600);
        repeat (4) drive(100);
        drive(100, 1'b1);
        repeat (15) drive(100);
        spike(600, 800, 200);  repeat (6) drive(100);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1023)) : 100,
                  ($urandom_range(0, 299) == 0));
        end

        repeat (20) drive(100);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
